// File: rtl/rf_writeback_queue.sv
// rf_writeback_queue
//   In-order write-back queue feeding the register bank's single write port.
//   Accepts results from the memory stage and the ALU (mem is older when both
//   arrive together), retires at most one entry per cycle unless held, and
//   exposes two forwarding lookups over the pending (not yet written) entries.
//
// Ports
//   clk, reset                   clock, synchronous active-high reset
//   mem_valid/mem_ready          memory-result handshake, mem_addr/mem_data payload
//   alu_valid/alu_ready          ALU-result handshake, alu_addr/alu_data payload
//   hold                         stalls retirement (never acceptance)
//   rf_write/rf_addr_d/rf_data   register-bank write port (head of queue)
//   fwd_addr_x -> fwd_hit_x/fwd_data_x   youngest pending value for an address
//   count                        occupied entries, 0..DEPTH
module rf_writeback_queue #(
   parameter int unsigned DEPTH  = 4,
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ADDR_W = 5
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     mem_valid,
   output logic                     mem_ready,
   input  logic [ADDR_W-1:0]        mem_addr,
   input  logic [DATA_W-1:0]        mem_data,
   input  logic                     alu_valid,
   output logic                     alu_ready,
   input  logic [ADDR_W-1:0]        alu_addr,
   input  logic [DATA_W-1:0]        alu_data,
   input  logic                     hold,
   output logic                     rf_write,
   output logic [ADDR_W-1:0]        rf_addr_d,
   output logic [DATA_W-1:0]        rf_data,
   input  logic [ADDR_W-1:0]        fwd_addr_a,
   input  logic [ADDR_W-1:0]        fwd_addr_b,
   output logic                     fwd_hit_a,
   output logic                     fwd_hit_b,
   output logic [DATA_W-1:0]        fwd_data_a,
   output logic [DATA_W-1:0]        fwd_data_b,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   logic [ADDR_W-1:0] addr_q [DEPTH];
   logic [DATA_W-1:0] data_q [DEPTH];
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  alu_slot;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              mem_enq, alu_enq, retire;

   // Readiness looks only at the registered count; a retirement in the same
   // cycle does not free a slot until the next cycle.
   always_comb begin
      mem_ready = !reset && (count_q <= CNT_W'(DEPTH - 1));
      alu_ready = !reset && ((count_q <= CNT_W'(DEPTH - 2)) ||
                             ((count_q == CNT_W'(DEPTH - 1)) && !mem_valid));
   end

   // Writes to register 0 complete the handshake but are dropped here.
   always_comb begin
      mem_enq  = mem_valid && mem_ready && (mem_addr != '0);
      alu_enq  = alu_valid && alu_ready && (alu_addr != '0);
      retire   = (count_q != '0) && !hold;
      // ALU lands behind the mem entry only if the mem entry was kept.
      alu_slot = wr_ptr_q + PTR_W'(mem_enq);
      wr_ptr_d = wr_ptr_q + PTR_W'(mem_enq) + PTR_W'(alu_enq);
      rd_ptr_d = rd_ptr_q + PTR_W'(retire);
      count_d  = count_q + CNT_W'(mem_enq) + CNT_W'(alu_enq) - CNT_W'(retire);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         count_q  <= '0;
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            addr_q[i] <= '0;
            data_q[i] <= '0;
         end
      end else begin
         count_q  <= count_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         if (mem_enq) begin
            addr_q[wr_ptr_q] <= mem_addr;
            data_q[wr_ptr_q] <= mem_data;
         end
         if (alu_enq) begin
            addr_q[alu_slot] <= alu_addr;
            data_q[alu_slot] <= alu_data;
         end
      end
   end

   // Head of queue drives the bank; when empty the stale slot is visible but
   // rf_write stays low.
   always_comb begin
      rf_write  = retire;
      rf_addr_d = addr_q[rd_ptr_q];
      rf_data   = data_q[rd_ptr_q];
      count     = count_q;
   end

   // Scan oldest to youngest so the last match (youngest) wins. The head is
   // included even when it retires this cycle.
   always_comb begin
      fwd_hit_a  = 1'b0;
      fwd_hit_b  = 1'b0;
      fwd_data_a = '0;
      fwd_data_b = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         if (CNT_W'(i) < count_q) begin
            if ((fwd_addr_a != '0) && (addr_q[rd_ptr_q + PTR_W'(i)] == fwd_addr_a)) begin
               fwd_hit_a  = 1'b1;
               fwd_data_a = data_q[rd_ptr_q + PTR_W'(i)];
            end
            if ((fwd_addr_b != '0) && (addr_q[rd_ptr_q + PTR_W'(i)] == fwd_addr_b)) begin
               fwd_hit_b  = 1'b1;
               fwd_data_b = data_q[rd_ptr_q + PTR_W'(i)];
            end
         end
      end
   end

endmodule

// File: tb/tb_rf_writeback_queue.sv
module tb_rf_writeback_queue;

   localparam int DEPTH  = 4;
   localparam int DATA_W = 32;
   localparam int ADDR_W = 5;

   logic              clk = 1'b0;
   logic              reset;
   logic              mem_valid, mem_ready, alu_valid, alu_ready, hold;
   logic [ADDR_W-1:0] mem_addr, alu_addr, rf_addr_d, fwd_addr_a, fwd_addr_b;
   logic [DATA_W-1:0] mem_data, alu_data, rf_data, fwd_data_a, fwd_data_b;
   logic              rf_write, fwd_hit_a, fwd_hit_b;
   logic [$clog2(DEPTH):0] count;

   rf_writeback_queue #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
      .clk        (clk),
      .reset      (reset),
      .mem_valid  (mem_valid),
      .mem_ready  (mem_ready),
      .mem_addr   (mem_addr),
      .mem_data   (mem_data),
      .alu_valid  (alu_valid),
      .alu_ready  (alu_ready),
      .alu_addr   (alu_addr),
      .alu_data   (alu_data),
      .hold       (hold),
      .rf_write   (rf_write),
      .rf_addr_d  (rf_addr_d),
      .rf_data    (rf_data),
      .fwd_addr_a (fwd_addr_a),
      .fwd_addr_b (fwd_addr_b),
      .fwd_hit_a  (fwd_hit_a),
      .fwd_hit_b  (fwd_hit_b),
      .fwd_data_a (fwd_data_a),
      .fwd_data_b (fwd_data_b),
      .count      (count)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [ADDR_W-1:0] a;
      logic [DATA_W-1:0] d;
   } ent_t;

   ent_t sb[$];
   ent_t exp_e;
   int   errors = 0;
   int   checks = 0;
   int   writes = 0;
   int   w0, maxc;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Monitor: every bank write must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (!reset && rf_write === 1'b1) begin
         writes++;
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h expected no write",
                     rf_addr_d, rf_data);
         end else begin
            exp_e = sb.pop_front();
            check("wb_addr", 32'(rf_addr_d), 32'(exp_e.a));
            check("wb_data", rf_data, exp_e.d);
         end
      end
   end

   // Offer one or both sources until accepted; expectations are queued in
   // acceptance order (mem before ALU in the same cycle).
   task automatic send(input logic mv, input logic [ADDR_W-1:0] ma, input logic [DATA_W-1:0] md,
                       input logic av, input logic [ADDR_W-1:0] aa, input logic [DATA_W-1:0] ad);
      logic mpend, apend, mgo, ago;
      mpend = mv;
      apend = av;
      mem_valid = mv; mem_addr = ma; mem_data = md;
      alu_valid = av; alu_addr = aa; alu_data = ad;
      for (int n = 0; n < 50 && (mpend || apend); n++) begin
         @(negedge clk);
         mgo = mpend && mem_ready;
         ago = apend && alu_ready;
         if (mgo && ma != '0) sb.push_back({ma, md});
         if (ago && aa != '0) sb.push_back({aa, ad});
         @(posedge clk); #1;
         if (mgo) begin mpend = 1'b0; mem_valid = 1'b0; end
         if (ago) begin apend = 1'b0; alu_valid = 1'b0; end
      end
      if (mpend || apend) begin
         checks++;
         errors++;
         $display("FAIL send_timeout: got no accept expected accept within 50 cycles");
         mem_valid = 1'b0;
         alu_valid = 1'b0;
      end
   endtask

   task automatic wait_empty(input string name);
      for (int n = 0; n < 60; n++) begin
         @(negedge clk);
         if (count == 0) break;
      end
      check(name, 32'(count), 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got no finish expected finish before time limit");
      $fatal(1);
   end

   initial begin
      reset = 1'b1; hold = 1'b0;
      mem_valid = 1'b0; mem_addr = '0; mem_data = '0;
      alu_valid = 1'b0; alu_addr = '0; alu_data = '0;
      fwd_addr_a = '0; fwd_addr_b = '0;

      @(negedge clk);
      check("reset_mem_ready", 32'(mem_ready), 0);
      check("reset_alu_ready", 32'(alu_ready), 0);
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      check("init_count", 32'(count), 0);
      check("init_rf_write", 32'(rf_write), 0);
      check("init_mem_ready", 32'(mem_ready), 1);
      check("init_alu_ready", 32'(alu_ready), 1);

      // Single ALU result
      @(posedge clk); #1;
      send(1'b0, '0, '0, 1'b1, 5'd5, 32'hDEADBEEF);
      fwd_addr_a = 5'd5;
      @(negedge clk);
      check("single_rf_write", 32'(rf_write), 1);
      check("single_rf_addr", 32'(rf_addr_d), 5);
      check("single_rf_data", rf_data, 32'hDEADBEEF);
      check("single_fwd_hit", 32'(fwd_hit_a), 1);
      check("single_fwd_data", fwd_data_a, 32'hDEADBEEF);
      @(negedge clk);
      check("single_after_write", 32'(rf_write), 0);
      check("single_after_count", 32'(count), 0);
      check("single_after_hit", 32'(fwd_hit_a), 0);
      check("single_after_fdata", fwd_data_a, 0);

      // Same-address ordering
      @(posedge clk); #1;
      hold = 1'b1;
      send(1'b1, 5'd3, 32'h11, 1'b1, 5'd3, 32'h22);
      fwd_addr_b = 5'd3;
      @(negedge clk);
      check("same_count", 32'(count), 2);
      check("same_fwd_hit_b", 32'(fwd_hit_b), 1);
      check("same_fwd_data_b", fwd_data_b, 32'h22);
      @(posedge clk); #1;
      hold = 1'b0;
      @(negedge clk);
      check("same_first_data", rf_data, 32'h11);
      @(negedge clk);
      check("same_second_data", rf_data, 32'h22);
      @(negedge clk);
      check("same_drained", 32'(count), 0);

      // Full / back-pressure
      @(posedge clk); #1;
      hold = 1'b1;
      send(1'b1, 5'd1, 32'hA1, 1'b1, 5'd2, 32'hA2);
      send(1'b1, 5'd3, 32'hA3, 1'b1, 5'd4, 32'hA4);
      @(negedge clk);
      check("full_count", 32'(count), 4);
      check("full_mem_ready", 32'(mem_ready), 0);
      check("full_alu_ready", 32'(alu_ready), 0);
      @(posedge clk); #1;
      hold = 1'b0;
      mem_valid = 1'b1; mem_addr = '0; mem_data = 32'hFFFF;
      @(negedge clk);
      check("full_retire_write", 32'(rf_write), 1);
      check("full_retire_mem_ready", 32'(mem_ready), 0);
      @(posedge clk); #1;
      hold = 1'b1;
      @(negedge clk);
      check("three_count", 32'(count), 3);
      check("three_mem_ready", 32'(mem_ready), 1);
      check("three_alu_ready_memv", 32'(alu_ready), 0);
      @(posedge clk); #1;
      mem_valid = 1'b0;
      @(negedge clk);
      check("three_zero_discard", 32'(count), 3);
      check("three_alu_ready", 32'(alu_ready), 1);
      @(posedge clk); #1;
      hold = 1'b0;
      wait_empty("full_drain");

      // Register 0
      @(posedge clk); #1;
      fwd_addr_a = '0;
      send(1'b0, '0, '0, 1'b1, 5'd0, 32'hFFFF);
      @(negedge clk);
      check("r0_count", 32'(count), 0);
      check("r0_rf_write", 32'(rf_write), 0);
      check("r0_fwd_hit", 32'(fwd_hit_a), 0);

      // Reset with pending entries
      @(posedge clk); #1;
      hold = 1'b1;
      send(1'b1, 5'd7, 32'h77, 1'b1, 5'd8, 32'h88);
      fwd_addr_a = 5'd7;
      @(negedge clk);
      check("pre_reset_count", 32'(count), 2);
      check("pre_reset_hit", 32'(fwd_hit_a), 1);
      @(posedge clk); #1;
      reset = 1'b1;
      mem_valid = 1'b1; mem_addr = 5'd9; mem_data = 32'h99;
      @(negedge clk);
      check("in_reset_mem_ready", 32'(mem_ready), 0);
      check("in_reset_alu_ready", 32'(alu_ready), 0);
      @(posedge clk); #1;
      reset = 1'b0; mem_valid = 1'b0; hold = 1'b0;
      sb.delete();
      @(negedge clk);
      check("flush_count", 32'(count), 0);
      check("flush_rf_write", 32'(rf_write), 0);
      check("flush_rf_addr", 32'(rf_addr_d), 0);
      check("flush_rf_data", rf_data, 0);
      check("flush_mem_ready", 32'(mem_ready), 1);
      check("flush_alu_ready", 32'(alu_ready), 1);
      check("flush_fwd_hit", 32'(fwd_hit_a), 0);
      check("flush_fwd_data", fwd_data_a, 0);

      // Wrap-around stream with hold toggling every 3 cycles
      @(posedge clk); #1;
      w0 = writes;
      maxc = 0;
      fork
         begin
            for (int k = 1; k <= 10; k++) begin
               send(1'b0, '0, '0, 1'b1, ADDR_W'(k), 32'(k * 32'h100));
            end
         end
         begin
            for (int c = 0; c < 45; c++) begin
               @(posedge clk); #1;
               if (c % 3 == 2) hold = !hold;
               @(negedge clk);
               if (int'(count) > maxc) maxc = int'(count);
            end
            @(posedge clk); #1;
            hold = 1'b0;
         end
      join
      wait_empty("wrap_drain");
      check("wrap_writes", 32'(writes - w0), 10);
      check("wrap_max_count_ok", 32'(maxc <= DEPTH), 1);
      check("wrap_sb_empty", 32'(sb.size()), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/rf_writeback_queue.md
# rf_writeback_queue

Write-back queue that produces the register bank's write port (`addr_d`, `data`, `write`). It accepts completed results from two sources, the ALU and the memory stage, through valid/ready handshakes. It buffers them in an in-order FIFO and retires at most one entry per cycle into the register bank, with a hold input that stalls retirement. Two forwarding lookup ports let decode read pending (not yet written) values so the bank's read ports never return stale data.

## Interface
- `DEPTH`, 4: queue entries; power of two, ≥ 2
- `DATA_W`, 32: result data width
- `ADDR_W`, 5: register address width
- `clk`  in  1  sole clock; all state updates on rising edge
- `reset`  in  1  synchronous, active-high reset
- `mem_valid` / `mem_ready`  in / out  1  memory-result handshake
- `mem_addr`, `mem_data`  in  ADDR_W, DATA_W  memory-result destination and value
- `alu_valid` / `alu_ready`  in / out  1  ALU-result handshake
- `alu_addr`, `alu_data`  in  ADDR_W, DATA_W  ALU-result destination and value
- `hold`  in  1  suppresses retirement this cycle
- `rf_write`  out  1  register-bank write enable
- `rf_addr_d`  out  ADDR_W  register-bank write address
- `rf_data`  out  DATA_W  register-bank write data
- `fwd_addr_a`, `fwd_addr_b`  in  ADDR_W  lookup addresses
- `fwd_hit_a`, `fwd_hit_b`  out  1  a pending entry matches
- `fwd_data_a`, `fwd_data_b`  out  DATA_W  youngest matching pending value, else 0
- `count`  out  $clog2(DEPTH)+1  occupied entries

## Operation
- The queue is a circular buffer: `rd_ptr`, `wr_ptr`, and a `count` of 0..DEPTH. Each entry holds {addr, data}.
- A transfer occurs on a source when valid && ready at the rising edge.
- Ready is based on the registered `count` only. It is not credited by a same-cycle retirement.
  - `mem_ready` = !reset && count ≤ DEPTH−1
  - `alu_ready` = !reset && (count ≤ DEPTH−2 || (count == DEPTH−1 && !mem_valid))
- Memory has priority: when both sources transfer in the same cycle, the mem entry is written to slot `wr_ptr` (older) and the ALU entry to `wr_ptr`+1 (younger).
- A transfer with addr == 0 completes its handshake but is discarded. It is not enqueued, `count` is unchanged, and `rf_write` is never asserted for address 0.
- Retirement is combinational from the head:
  - `rf_write` = (count ≠ 0) && !hold
  - `rf_addr_d` / `rf_data` = head entry
- When `rf_write` is high at an edge, `rd_ptr` advances by 1.
- Count update: count_next = count + enqueued (0, 1, 2) − retired (0, 1). Simultaneous enqueue and retire is legal in every state.
- Pointers wrap modulo DEPTH.
- Forwarding: `fwd_hit_x` = 1 iff some occupied entry has addr == `fwd_addr_x`, and `fwd_addr_x` ≠ 0.
  - `fwd_data_x` = data of the youngest such entry (closest to `wr_ptr`−1); 0 when there is no hit.
  - The lookup covers registered queue contents only. Same-cycle incoming results are not searched.
  - The head entry being retired this cycle is still searched.
- Entries to the same address retire in acceptance order, so the bank's final value is the youngest.

## Timing
- Reset (synchronous, high at an edge):
  - `count`, `rd_ptr`, `wr_ptr` = 0; all entry storage = 0
  - `rf_write` = 0, `rf_addr_d` = 0, `rf_data` = 0
  - `fwd_hit_*` = 0, `fwd_data_*` = 0
  - Both readies are 0 while `reset` is high and 1 in the first cycle after it.
- Latency: a result accepted at edge N appears at the head, and in the forwarding lookup, during cycle N+1. Minimum accept-to-bank-write latency is 1 cycle.
- Throughput: at most 2 accepts and 1 retire per cycle.
- Full (count == DEPTH): both readies are 0, even if a retirement happens this cycle.
- Empty: `rf_write` = 0 regardless of `hold`; `rf_addr_d` / `rf_data` show the stale slot at `rd_ptr`.
- Reset mid-operation flushes all pending entries; they are never written to the bank. A source handshake offered during the reset cycle is not accepted.
- `hold` has no effect on acceptance, only on retirement.

## Test plan
- **Reset:** pulse reset with queue non-empty -> the next cycle shows count=0, rf_write=0, rf_addr_d=0, rf_data=0, both readies=1, fwd_hit_a=0.
- **Single ALU result:** alu addr=5, data=0xDEADBEEF accepted at edge 1, hold=0 -> cycle 2 shows rf_write=1, rf_addr_d=5, rf_data=0xDEADBEEF, and fwd_addr_a=5 gives hit=1 with data 0xDEADBEEF -> cycle 3 shows rf_write=0, count=0.
- **Same-address ordering:** hold=1; mem (3, 0x11) and alu (3, 0x22) in the same cycle -> count=2, fwd_data_b=0x22 for address 3. Release hold -> the bank sees (3, 0x11) then (3, 0x22) on consecutive cycles.
- **Full / back-pressure:** hold=1, enqueue 4 entries -> count=4, mem_ready=alu_ready=0. After one retirement, count=3; with mem_valid=1 -> mem_ready=1, alu_ready=0. With mem_valid=0 -> alu_ready=1.
- **Register 0:** alu addr=0, data=0xFFFF accepted -> count stays 0, rf_write stays 0, and fwd_addr_a=0 gives hit=0.
- **Wrap-around:** stream 10 ALU results (addr 1..10, data = addr·0x100) with hold toggling every 3 cycles -> all 10 are written to the bank in order, and count never exceeds 4.
